// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Round-robin scheduler that shares one shift-add multiplier among NREQ
//   requesters. It latches the winner's operands, holds the multiplier start
//   level until the multiplier reports ready, captures the product, and then
//   presents it together with the requester id until the consumer accepts it.
//   A watchdog bounds the time spent waiting on the multiplier.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   req          per-requester request level, held until gnt
//   a_in, b_in   packed operands, requester i in bits [i*N +: N]
//   gnt          one-hot, one-cycle pulse: that requester's operands were taken
//   busy         high whenever the scheduler is not idle
//   mul_start    start level to the multiplier sequencer
//   mul_a, mul_b registered operands to the multiplier datapath
//   mul_ready    multiplier done
//   mul_product  multiplier result, valid while mul_ready
//   rsp_valid    response available
//   rsp_ready    consumer accepts response
//   rsp_id       requester owning the response
//   rsp_product  captured product (0 when the watchdog expired)
//   rsp_err      watchdog expired for this response
module mult_arbiter #(
   parameter int NREQ    = 4,
   parameter int N       = 8,
   parameter int TIMEOUT = 31
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*N-1:0]       a_in,
   input  logic [NREQ*N-1:0]       b_in,
   output logic [NREQ-1:0]         gnt,
   output logic                    busy,
   output logic                    mul_start,
   output logic [N-1:0]            mul_a,
   output logic [N-1:0]            mul_b,
   input  logic                    mul_ready,
   input  logic [2*N-1:0]          mul_product,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [2*N-1:0]          rsp_product,
   output logic                    rsp_err
);

   localparam int IDW = $clog2(NREQ);
   // Watchdog only ever needs to hold values 0..TIMEOUT-1.
   localparam int WDW = $clog2(TIMEOUT);

   localparam logic [WDW-1:0]  WD_LAST  = WDW'(TIMEOUT - 1);
   localparam logic [IDW:0]    NREQ_EXT = (IDW + 1)'(NREQ);
   localparam logic [IDW-1:0]  ID_LAST  = IDW'(NREQ - 1);
   localparam logic [NREQ-1:0] GNT_ONE  = NREQ'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] ptr_next;
   logic [IDW-1:0] win_id;
   logic           win_any;
   logic [IDW:0]   rot_idx;
   logic [WDW-1:0] wdog;

   // Round-robin pick: scan requesters starting at ptr, wrapping around.
   // The scan runs from the farthest offset down to offset 0 so that the
   // last hit written is the nearest one at or after the pointer.
   always_comb begin
      win_any = 1'b0;
      win_id  = '0;
      rot_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         rot_idx = {1'b0, ptr} + (IDW + 1)'(k);
         if (rot_idx >= NREQ_EXT) begin
            rot_idx = rot_idx - NREQ_EXT;
         end
         if (req[rot_idx[IDW-1:0]]) begin
            win_any = 1'b1;
            win_id  = rot_idx[IDW-1:0];
         end
      end
   end

   // Next search starts just after the winner, modulo NREQ.
   assign ptr_next = (win_id == ID_LAST) ? '0 : win_id + 1'b1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Ready has priority over the watchdog when both occur in the same cycle.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (win_any) state_next = S_RUN;
         S_RUN:  if (mul_ready || (wdog == WD_LAST)) state_next = S_RESP;
         S_RESP: if (rsp_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Status and the multiplier start level decode straight from state, so
   // they drop in the same cycle as an asynchronous reset. Start falls in
   // RESP, which together with the mandatory IDLE cycle gives the multiplier
   // at least two low cycles between jobs.
   assign busy      = (state != S_IDLE);
   assign mul_start = (state == S_RUN);
   assign rsp_valid = (state == S_RESP);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gnt         <= '0;
         ptr         <= '0;
         wdog        <= '0;
         mul_a       <= '0;
         mul_b       <= '0;
         rsp_id      <= '0;
         rsp_product <= '0;
         rsp_err     <= 1'b0;
      end else begin
         gnt <= '0;
         case (state)
            S_IDLE: begin
               if (win_any) begin
                  gnt    <= GNT_ONE << win_id;
                  mul_a  <= a_in[win_id*N +: N];
                  mul_b  <= b_in[win_id*N +: N];
                  rsp_id <= win_id;
                  ptr    <= ptr_next;
                  wdog   <= '0;
               end
            end
            S_RUN: begin
               wdog <= wdog + 1'b1;
               if (mul_ready) begin
                  rsp_product <= mul_product;
                  rsp_err     <= 1'b0;
               end else if (wdog == WD_LAST) begin
                  rsp_product <= '0;
                  rsp_err     <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter
//   Drives mult_arbiter with directed scenarios and randomized traffic. A
//   behavioural multiplier answers mul_start after a programmable latency
//   (or never, to trip the watchdog). A transaction-level reference model
//   predicts grants, operands, products and status for every cycle.
module tb_mult_arbiter;

   localparam int NREQ    = 4;
   localparam int N       = 8;
   localparam int TIMEOUT = 31;
   localparam int IDW     = $clog2(NREQ);

   logic                clock = 1'b0;
   logic                reset = 1'b0;
   logic [NREQ-1:0]     req = '0;
   logic [NREQ*N-1:0]   a_in = '0;
   logic [NREQ*N-1:0]   b_in = '0;
   logic [NREQ-1:0]     gnt;
   logic                busy;
   logic                mul_start;
   logic [N-1:0]        mul_a;
   logic [N-1:0]        mul_b;
   logic                mul_ready = 1'b0;
   logic [2*N-1:0]      mul_product = '0;
   logic                rsp_valid;
   logic                rsp_ready = 1'b1;
   logic [IDW-1:0]      rsp_id;
   logic [2*N-1:0]      rsp_product;
   logic                rsp_err;

   mult_arbiter #(.NREQ(NREQ), .N(N), .TIMEOUT(TIMEOUT)) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .a_in        (a_in),
      .b_in        (b_in),
      .gnt         (gnt),
      .busy        (busy),
      .mul_start   (mul_start),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_ready   (mul_ready),
      .mul_product (mul_product),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_product (rsp_product),
      .rsp_err     (rsp_err)
   );

   always #5 clock = ~clock;

   // Behavioural multiplier: ready after mlat start cycles, never if stuck.
   // With mglitch set it toggles ready randomly while not started.
   int  mlat    = 2;
   bit  mstuck  = 1'b0;
   bit  mglitch = 1'b0;
   int  mcnt    = 0;

   always @(posedge clock) begin
      #2;
      if (mul_start) begin
         mcnt = mcnt + 1;
         mul_ready = !mstuck && (mcnt >= mlat);
         mul_product = mul_ready ? ((2*N)'(mul_a) * (2*N)'(mul_b)) : (2*N)'($urandom);
      end else begin
         mcnt = 0;
         mul_ready = mglitch ? 1'($urandom_range(0, 1)) : 1'b0;
         mul_product = (2*N)'($urandom);
      end
   end

   // Reference model: one outstanding job at a time, tracked as
   // open (granted, not yet accepted) and done (result known).
   int             r_ptr  = 0;
   bit             r_open = 1'b0;
   bit             r_done = 1'b0;
   int             r_runs = 0;
   int             r_w    = 0;
   logic [NREQ-1:0] e_gnt  = '0;
   logic [N-1:0]   e_mul_a = '0;
   logic [N-1:0]   e_mul_b = '0;
   int             e_id   = 0;
   logic [2*N-1:0] e_prod = '0;
   bit             e_err  = 1'b0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ptr = 0; r_open = 1'b0; r_done = 1'b0; r_runs = 0;
         e_gnt = '0; e_mul_a = '0; e_mul_b = '0; e_id = 0; e_prod = '0; e_err = 1'b0;
      end else begin
         e_gnt = '0;
         if (!r_open) begin
            if (req != '0) begin
               r_w = -1;
               for (int k = 0; k < NREQ; k++)
                  if (r_w < 0 && req[(r_ptr + k) % NREQ]) r_w = (r_ptr + k) % NREQ;
               r_open = 1'b1; r_done = 1'b0; r_runs = 0;
               e_gnt[r_w] = 1'b1;
               e_mul_a = a_in[r_w*N +: N];
               e_mul_b = b_in[r_w*N +: N];
               e_id = r_w;
               r_ptr = (r_w + 1) % NREQ;
            end
         end else if (!r_done) begin
            r_runs = r_runs + 1;
            if (mul_ready) begin
               r_done = 1'b1; e_prod = (2*N)'(e_mul_a) * (2*N)'(e_mul_b); e_err = 1'b0;
            end else if (r_runs == TIMEOUT) begin
               r_done = 1'b1; e_prod = '0; e_err = 1'b1;
            end
         end else if (rsp_ready) begin
            r_open = 1'b0;
         end
      end
   end

   int checks = 0;
   int errs   = 0;
   int glog[$];
   bit hold_after = 1'b0;
   int low_cnt = 100;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] rnd_op();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         default: return N'($urandom);
      endcase
   endfunction

   task automatic new_ops(input int i);
      a_in[i*N +: N] = rnd_op();
      b_in[i*N +: N] = rnd_op();
   endtask

   task automatic set_ops(input int i, input int a, input int b);
      a_in[i*N +: N] = N'(a);
      b_in[i*N +: N] = N'(b);
   endtask

   // One clock: compare every output with the model, then let requesters react to gnt.
   task automatic cycle();
      @(posedge clock);
      #1;
      chk("gnt", gnt, e_gnt);
      chk("busy", busy, r_open);
      chk("mul_start", mul_start, r_open && !r_done);
      chk("rsp_valid", rsp_valid, r_open && r_done);
      chk("mul_a", mul_a, e_mul_a);
      chk("mul_b", mul_b, e_mul_b);
      chk("rsp_id", rsp_id, e_id);
      chk("rsp_product", rsp_product, e_prod);
      chk("rsp_err", rsp_err, e_err);
      if (mul_start) begin
         if (low_cnt > 0) chk("start_gap", low_cnt >= 2, 1);
         low_cnt = 0;
      end else begin
         low_cnt++;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            glog.push_back(i);
            if (hold_after) new_ops(i);
            else req[i] = 1'b0;
         end
      end
   endtask

   task automatic reset_dut();
      req = '0;
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      low_cnt = 100;
      glog.delete();
   endtask

   task automatic wait_rsp();
      bit ok;
      ok = rsp_valid;
      for (int i = 0; i < 200 && !ok; i++) begin
         cycle();
         if (rsp_valid) ok = 1'b1;
      end
      chk("rsp_wait", ok, 1);
   endtask

   task automatic wait_grants(input int n);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         cycle();
         if (glog.size() >= n) ok = 1'b1;
      end
      chk("grant_wait", ok, 1);
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      req = '0;
      hold_after = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         cycle();
         if (!busy) ok = 1'b1;
      end
      chk("drain", ok, 1);
   endtask

   initial begin
      int runs;
      bit ok;
      logic [2*N-1:0] held;
      int exp_order[6];

      #1;
      reset_dut();
      chk("rst_busy", busy, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_product", rsp_product, 0);

      // Single request.
      mlat = 2;
      set_ops(1, 13, 11);
      req = 4'b0010;
      cycle();
      chk("t1_gnt", gnt, 4'b0010);
      chk("t1_mul_a", mul_a, 13);
      chk("t1_mul_b", mul_b, 11);
      cycle();
      chk("t1_gnt_pulse", gnt, 0);
      wait_rsp();
      chk("t1_id", rsp_id, 1);
      chk("t1_prod", rsp_product, 143);
      chk("t1_err", rsp_err, 0);
      drain();

      // Contention: all four held.
      reset_dut();
      for (int i = 0; i < NREQ; i++) set_ops(i, 10 * (i + 1), 3 + 2 * i);
      hold_after = 1'b1;
      req = 4'b1111;
      mlat = 3;
      wait_grants(5);
      drain();
      exp_order = '{0, 1, 2, 3, 0, 0};
      for (int k = 0; k < 5; k++) chk("t2_order", (k < glog.size()) ? glog[k] : -1, exp_order[k]);

      // Pointer wrap.
      reset_dut();
      req = 4'b0100; new_ops(2);
      wait_grants(1); drain();
      req = 4'b0011; new_ops(0); new_ops(1);
      wait_grants(3); drain();
      req = 4'b1000; new_ops(3);
      wait_grants(4); drain();
      req = 4'b1001; new_ops(0); new_ops(3);
      wait_grants(6); drain();
      exp_order = '{2, 0, 1, 3, 0, 3};
      for (int k = 0; k < 6; k++) chk("t3_order", (k < glog.size()) ? glog[k] : -1, exp_order[k]);

      // Backpressure, with spurious ready pulses while not running.
      mglitch = 1'b1;
      rsp_ready = 1'b0;
      set_ops(0, 255, 255);
      req = 4'b0001;
      wait_rsp();
      chk("t4_prod", rsp_product, 65025);
      set_ops(2, 6, 7);
      req[2] = 1'b1;
      held = rsp_product;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("t4_valid", rsp_valid, 1);
         chk("t4_stable", rsp_product, held);
         chk("t4_no_gnt", gnt, 0);
         chk("t4_start", mul_start, 0);
      end
      rsp_ready = 1'b1;
      cycle();
      chk("t4_idle", busy, 0);
      cycle();
      chk("t4_next_gnt", gnt, 4'b0100);
      drain();
      mglitch = 1'b0;

      // Watchdog.
      mstuck = 1'b1;
      set_ops(0, 9, 9);
      req = 4'b0001;
      cycle();
      runs = 0; ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (mul_start) runs++;
         if (rsp_valid) ok = 1'b1; else cycle();
      end
      chk("t5_seen", ok, 1);
      chk("t5_runs", runs, TIMEOUT);
      chk("t5_err", rsp_err, 1);
      chk("t5_prod", rsp_product, 0);
      mstuck = 1'b0;
      drain();
      set_ops(1, 200, 250);
      req = 4'b0010;
      wait_rsp();
      chk("t5_ok_err", rsp_err, 0);
      chk("t5_ok_prod", rsp_product, 50000);
      drain();

      // Reset in the middle of a job.
      mlat = 20;
      set_ops(1, 3, 3);
      req = 4'b0010;
      cycle(); cycle(); cycle();
      #3;
      reset = 1'b1;
      #1;
      chk("t6_start", mul_start, 0);
      chk("t6_gnt", gnt, 0);
      chk("t6_valid", rsp_valid, 0);
      chk("t6_busy", busy, 0);
      req = '0;
      cycle();
      reset = 1'b0;
      low_cnt = 100;
      mlat = 3;
      set_ops(2, 21, 12);
      req = 4'b0100;
      cycle();
      chk("t6_gnt_after", gnt, 4'b0100);
      wait_rsp();
      chk("t6_id", rsp_id, 2);
      chk("t6_prod", rsp_product, 252);
      drain();

      // Randomized traffic.
      reset_dut();
      mglitch = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && $urandom_range(0, 7) == 0) begin
               req[i] = 1'b1;
               new_ops(i);
            end else if (req[i] && $urandom_range(0, 31) == 0) begin
               req[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         if (!mul_start) begin
            mlat = $urandom_range(1, N + 1);
            mstuck = ($urandom_range(0, 39) == 0);
         end
         hold_after = 1'($urandom_range(0, 1));
         cycle();
      end
      mstuck = 1'b0;
      mglitch = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
